// File: rtl/route_input_unit.sv
// Per-link input stage of the 7-port crossbar: buffers arriving packets, looks up a
// multicast port mask in the routing table and delivers the packet to every selected mux.
module route_input_unit #(
  parameter int DataWidth         = 256,
  parameter int IndexPos          = 128,
  parameter int IndexWidth        = 16,
  parameter int RoutingTableWidth = 32,
  parameter int RoutingTablesize  = 256,
  parameter int InFIFODepth       = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DataWidth-1:0]                in_data,
  output logic                                in_avail,
  input  logic                                cfg_we,
  input  logic [$clog2(RoutingTablesize)-1:0] cfg_addr,
  input  logic [RoutingTableWidth-1:0]        cfg_data,
  input  logic [6:0]                          out_avail,
  output logic [DataWidth-1:0]                out_data_local,
  output logic [DataWidth-1:0]                out_data_yneg,
  output logic [DataWidth-1:0]                out_data_ypos,
  output logic [DataWidth-1:0]                out_data_xpos,
  output logic [DataWidth-1:0]                out_data_xneg,
  output logic [DataWidth-1:0]                out_data_zpos,
  output logic [DataWidth-1:0]                out_data_zneg,
  output logic [6:0]                          out_stall,
  output logic [15:0]                         drop_cnt,
  output logic                                overflow,
  output logic [1:0]                          dbg_state
);

  localparam int AW = $clog2(RoutingTablesize);
  localparam int PW = $clog2(InFIFODepth);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOOKUP = 2'd1, S_SEND = 2'd2} state_t;

  state_t                 r_state;
  logic [DataWidth-1:0]   r_fifo [InFIFODepth];
  logic [6:0]             r_table [RoutingTablesize];
  logic [PW:0]            r_wr_ptr;
  logic [PW:0]            r_rd_ptr;
  logic [DataWidth-1:0]   r_hold;
  logic [6:0]             r_entry_mask;
  logic [6:0]             r_pending;
  logic [15:0]            r_drop_cnt;
  logic                   r_overflow;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic [DataWidth-1:0]   w_head;
  logic [AW-1:0]          w_head_idx;
  logic [6:0]             w_serve;
  logic [6:0]             w_remain;
  logic                   w_unused_cfg;
  logic [IndexWidth-1:0]  w_unused_idx;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = in_data[DataWidth-1] && !w_full;
  assign w_head     = r_fifo[r_rd_ptr[PW-1:0]];
  assign w_head_idx = w_head[IndexPos +: AW];
  assign w_serve    = (r_state == S_SEND) ? (r_pending & out_avail) : 7'h00;
  assign w_remain   = r_pending & ~w_serve;

  assign w_unused_cfg = ^cfg_data[RoutingTableWidth-1:7];
  assign w_unused_idx = w_head[IndexPos +: IndexWidth];

  // Storage without reset; the table read samples the old entry on a same-address write.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= in_data;
    if (cfg_we) r_table[cfg_addr] <= cfg_data[6:0];
    r_entry_mask <= r_table[w_head_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_hold     <= '0;
      r_pending  <= 7'h00;
      r_drop_cnt <= 16'h0000;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (in_data[DataWidth-1] && w_full) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_hold   <= w_head;
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_pending <= r_entry_mask;
          if (r_entry_mask == 7'h00) begin
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_pending <= w_remain;
          if (w_remain == 7'h00) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_avail       = ~w_full;
  assign out_stall      = ~w_serve;
  assign out_data_local = w_serve[0] ? r_hold : '0;
  assign out_data_yneg  = w_serve[1] ? r_hold : '0;
  assign out_data_ypos  = w_serve[2] ? r_hold : '0;
  assign out_data_xpos  = w_serve[3] ? r_hold : '0;
  assign out_data_xneg  = w_serve[4] ? r_hold : '0;
  assign out_data_zpos  = w_serve[5] ? r_hold : '0;
  assign out_data_zneg  = w_serve[6] ? r_hold : '0;
  assign drop_cnt       = r_drop_cnt;
  assign overflow       = r_overflow;
  assign dbg_state      = r_state;

endmodule
